// File: rtl/rr_grant_if.sv
// Request/grant bundle between requesters (master) and rr_grant_encoder (slave).
interface rr_grant_if #(
  parameter int N = 4,
  parameter int W = $clog2(N)
);
  logic [N-1:0] req;
  logic         ack;
  logic         grant_valid;
  logic [W-1:0] grant_idx;
  logic [N-1:0] grant_oh;

  modport master (output req, ack, input grant_valid, grant_idx, grant_oh);
  modport slave  (input req, ack, output grant_valid, grant_idx, grant_oh);
endinterface

// File: rtl/rr_grant_encoder.sv
// Registered request arbiter presenting the winner as index + one-hot, held until ack.
// Define RR_GRANT_ROUND_ROBIN_EN for a rotating priority pointer; otherwise lowest index wins.
module rr_grant_encoder #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic      clk,
  input  logic      rst_n,
  rr_grant_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state;
  logic [W-1:0] ptr;
  logic [W-1:0] arb_ptr;
  logic [N-1:0] arb_req;
  logic         rearb;
  logic         found;
  logic [W-1:0] win;
  logic [W:0]   sum;
  logic [N-1:0] win_oh;

`ifdef RR_GRANT_ROUND_ROBIN_EN
  logic [W-1:0] inc_idx;
  assign inc_idx = (bus.grant_idx == W'(N-1)) ? '0 : bus.grant_idx + 1'b1;

  // Pointer only moves on a consumed grant; a withdrawal leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        ptr <= '0;
    else if (state == GRANT && bus.ack) ptr <= inc_idx;
  end
`else
  assign ptr = '0;
`endif

  always_comb begin
    rearb   = 1'b0;
    arb_req = bus.req;
    arb_ptr = ptr;
    case (state)
      IDLE: rearb = 1'b1;
      GRANT: begin
        if (bus.ack) begin
          rearb                  = 1'b1;
          arb_req[bus.grant_idx] = 1'b0;
`ifdef RR_GRANT_ROUND_ROBIN_EN
          arb_ptr = inc_idx;
`endif
        end else if (!bus.req[bus.grant_idx]) begin
          rearb = 1'b1;
        end
      end
      default: rearb = 1'b0;
    endcase
  end

  // Walk the search order backwards so the nearest-to-pointer hit is written last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, arb_ptr} + (W+1)'(k);
      if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
      if (arb_req[sum[W-1:0]]) begin
        found = 1'b1;
        win   = sum[W-1:0];
      end
    end
  end

  assign win_oh = {{(N-1){1'b0}}, 1'b1} << win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bus.grant_valid <= 1'b0;
      bus.grant_idx   <= '0;
      bus.grant_oh    <= '0;
    end else if (rearb) begin
      if (found) begin
        state           <= GRANT;
        bus.grant_valid <= 1'b1;
        bus.grant_idx   <= win;
        bus.grant_oh    <= win_oh;
      end else begin
        state           <= IDLE;
        bus.grant_valid <= 1'b0;
        bus.grant_oh    <= '0;
      end
    end
  end

endmodule
